// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART at CPU address 001h: single-byte TX holding register feeding a shifter,
// oversampled RX deserialiser feeding a small FIFO, and a one-cycle registered status/data read port.
module uart_mmio #(
    parameter int CLK_PER_BIT = 16,
    parameter int RX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        tx,
    input  logic        rx
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      hold_data_q, hold_data_d;
    logic            tx_busy_q, tx_busy_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [RX_DEPTH];
    logic [7:0]      mem_d [RX_DEPTH];
    logic            rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d, tx_ovr_q, tx_ovr_d;
    logic [15:0]     rd_data_q, rd_data_d;

    rx_state_t       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;

    logic rd_req, wr_req, fifo_empty, fifo_full, pop, rx_push, rx_bad_stop, tx_done;
    logic unused_wr_hi;

    assign unused_wr_hi = ^wr_data[15:8];
    assign rd_req  = sel & rd;
    assign wr_req  = sel & wr;
    assign rd_data = rd_data_q;
    assign tx      = tx_shift_q[0];

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop         = rd_req & ~fifo_empty;
    assign rx_push     = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST) && rx_sync_q;
    assign rx_bad_stop = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST) && !rx_sync_q;
    assign tx_done     = tx_busy_q && (tx_cnt_q == CNT_LAST) && (tx_bit_q == 4'd9);

    // The shifter idles at all-ones so tx comes straight off a flop and stays glitch-free.
    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        tx_busy_d   = tx_busy_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_ovr_d    = tx_ovr_q & ~rd_req;

        if (tx_busy_q) begin
            if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d  = 1'b0;
                    tx_bit_d   = '0;
                    tx_shift_d = '1;
                end else begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
        end

        // Chaining on tx_done keeps back-to-back frames free of idle cycles.
        if ((!tx_busy_q || tx_done) && hold_full_q) begin
            tx_shift_d  = {1'b1, hold_data_q, 1'b0};
            tx_busy_d   = 1'b1;
            tx_cnt_d    = '0;
            tx_bit_d    = '0;
            hold_full_d = 1'b0;
        end

        if (wr_req) begin
            if (hold_full_q) begin
                tx_ovr_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_data_d = wr_data[7:0];
            end
        end
    end

    // A pop frees the head slot first, so a push into a full FIFO on the same edge still lands.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rx_ovr_d    = rx_ovr_q & ~rd_req;
        frame_err_d = (frame_err_q & ~rd_req) | rx_bad_stop;
        rd_data_d   = rd_data_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (rx_push) begin
            if (!fifo_full || pop) begin
                mem_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
        if (rd_req) begin
            rd_data_d = {3'b000, tx_ovr_q, frame_err_q, rx_ovr_q, hold_full_q, ~fifo_empty,
                         fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            tx_busy_q   <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovr_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            tx_busy_q   <= tx_busy_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            tx_ovr_q    <= tx_ovr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Start is confirmed at mid-bit; every later sample lands mid-bit one bit period apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule
